// File: rtl/frame_sync_ctrl.sv
// frame_sync_ctrl: sync-word frame acquisition with lock/miss tracking; emits payload_bit/payload_valid with frame_start/frame_end markers, plus locked and sync_err status.
module frame_sync_ctrl #(
  parameter int SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = 4'b1011,
  parameter int PAYLOAD_LEN = 8,
  parameter int LOCK_CNT = 2,
  parameter int MISS_CNT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic x_valid,
  input  logic x,
  output logic payload_bit,
  output logic payload_valid,
  output logic frame_start,
  output logic frame_end,
  output logic locked,
  output logic sync_err
);
  localparam int F = PAYLOAD_LEN + SYNC_LEN;
  localparam int PW = $clog2(F);
  localparam logic [PW-1:0] POS_SYNC = PW'(F - 1);
  localparam logic [PW-1:0] POS_PEND = PW'(PAYLOAD_LEN - 1);
  localparam logic [PW-1:0] POS_PLEN = PW'(PAYLOAD_LEN);
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [3:0] hit_q, hit_d, miss_q, miss_d, hit_inc, miss_inc;
  logic [SYNC_LEN-2:0] shreg_q, shreg_d;
  logic [SYNC_LEN-1:0] win;
  logic match, at_sync, in_pay;
  logic pb_q, pb_d, pv_q, pv_d, fs_q, fs_d, fe_q, fe_d, se_q, se_d;
  assign win = {shreg_q, x};
  assign match = win == SYNC_PAT;
  assign at_sync = pos_q == POS_SYNC;
  assign in_pay = pos_q < POS_PLEN;
  assign hit_inc = hit_q + 4'd1;
  assign miss_inc = miss_q + 4'd1;
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    hit_d = hit_q;
    miss_d = miss_q;
    shreg_d = shreg_q;
    pv_d = 1'b0;
    pb_d = 1'b0;
    fs_d = 1'b0;
    fe_d = 1'b0;
    se_d = 1'b0;
    if (x_valid) begin
      shreg_d = win[SYNC_LEN-2:0];
      case (state_q)
        SEARCH: if (match) begin
          pos_d = '0;
          hit_d = 4'd1;
          miss_d = '0;
          state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
        VERIFY: if (!at_sync) pos_d = pos_q + 1'b1;
        else if (match) begin
          pos_d = '0;
          hit_d = hit_inc;
          if (hit_inc == 4'(LOCK_CNT)) begin
            state_d = LOCKED;
            miss_d = '0;
          end
        end else begin
          pos_d = '0;
          hit_d = '0;
          state_d = SEARCH;
        end
        LOCKED: begin
          pos_d = at_sync ? '0 : pos_q + 1'b1;
          pv_d = in_pay;
          pb_d = in_pay & x;
          fs_d = in_pay && pos_q == '0;
          fe_d = pos_q == POS_PEND;
          if (at_sync) begin
            miss_d = match ? '0 : miss_inc;
            se_d = !match;
            if (!match && miss_inc == 4'(MISS_CNT)) begin
              state_d = SEARCH;
              hit_d = '0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      pos_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
      shreg_q <= '0;
      pv_q <= 1'b0;
      pb_q <= 1'b0;
      fs_q <= 1'b0;
      fe_q <= 1'b0;
      se_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      shreg_q <= shreg_d;
      pv_q <= pv_d;
      pb_q <= pb_d;
      fs_q <= fs_d;
      fe_q <= fe_d;
      se_q <= se_d;
    end
  end
  assign payload_bit = pb_q;
  assign payload_valid = pv_q;
  assign frame_start = fs_q;
  assign frame_end = fe_q;
  assign sync_err = se_q;
  assign locked = state_q == LOCKED;
endmodule

// File: tb/tb_frame_sync_ctrl.sv
// tb_frame_sync_ctrl: directed frame-level scoreboard bench for frame_sync_ctrl
module tb_frame_sync_ctrl;
  logic clk, rst, x_valid, x;
  logic payload_bit, payload_valid, frame_start, frame_end, locked, sync_err;
  logic [5:0] sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic lk_cur = 1'b0;
  frame_sync_ctrl dut (
    .clk(clk),
    .rst(rst),
    .x_valid(x_valid),
    .x(x),
    .payload_bit(payload_bit),
    .payload_valid(payload_valid),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .locked(locked),
    .sync_err(sync_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [5:0] e);
    logic [5:0] got;
    got = {locked, sync_err, payload_valid, payload_bit, frame_start, frame_end};
    n_chk++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed{lk,se,pv,pb,fs,fe}=%b expected=%b", tag, $time, got, e);
    end
  endtask
  task automatic step(input string tag, input logic v, input logic xb, input logic [5:0] e);
    @(negedge clk);
    x_valid = v;
    x = xb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk(tag, sb.pop_front());
  endtask
  task automatic frame(input string tag, input logic [3:0] s, input logic [7:0] p, input bit emit,
                       input bit serr, input bit lk_after, input bit gap, input int n = 12);
    logic [11:0] b;
    logic lk, pv;
    b = {s, p};
    for (int i = 0; i < n; i++) begin
      lk = (i < 3) ? lk_cur : lk_after;
      pv = emit && i >= 4;
      step(tag, 1'b1, b[11-i], {lk, serr && i == 3, pv, pv & b[11-i], emit && i == 4, emit && i == 11});
      if (gap) step({tag, "_gap"}, 1'b0, 1'($urandom_range(1)), {lk, 5'b0});
    end
    if (n >= 4) lk_cur = lk_after;
  endtask
  initial begin
    rst = 1'b1;
    x_valid = 1'b0;
    x = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 6'b0);
    @(negedge clk);
    rst = 1'b0;
    frame("acq_f1", 4'b1011, 8'b10100101, 0, 0, 0, 0);
    frame("acq_f2", 4'b1011, 8'b00111100, 1, 0, 1, 0);
    frame("acq_f3", 4'b1011, 8'b11110000, 1, 0, 1, 0);
    frame("miss1", 4'b1001, 8'b11001010, 1, 1, 1, 0);
    frame("good1", 4'b1011, 8'b01010011, 1, 0, 1, 0);
    frame("miss1b", 4'b1001, 8'b10011001, 1, 1, 1, 0);
    frame("good2", 4'b1011, 8'b11100111, 1, 0, 1, 0);
    frame("bad_a", 4'b0000, 8'b10110110, 1, 1, 1, 0);
    frame("bad_b", 4'b0000, 8'b00000000, 0, 1, 0, 0);
    frame("reacq1", 4'b1011, 8'b01101011, 0, 0, 0, 0);
    frame("reacq2", 4'b1011, 8'b10010110, 1, 0, 1, 0);
    frame("gapped", 4'b1011, 8'b11110000, 1, 0, 1, 1);
    frame("after_gap", 4'b1011, 8'b00001111, 1, 0, 1, 0);
    frame("pre_rst", 4'b1011, 8'b10100101, 1, 0, 1, 0, 7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", 6'b0);
    @(negedge clk);
    rst = 1'b0;
    lk_cur = 1'b0;
    frame("post_rst1", 4'b1011, 8'b11001100, 0, 0, 0, 0);
    frame("post_rst2", 4'b1011, 8'b00110011, 1, 0, 1, 0);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    lk_cur = 1'b0;
    frame("overlap1", 4'b1011, 8'b01100000, 0, 0, 0, 0);
    frame("overlap2", 4'b1011, 8'b10101010, 1, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
